// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through one ripple slice with a registered carry.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output overflow_out.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             sub_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             busy,
   output logic             done
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             overflow_out
`endif
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_out_q, carry_out_d;

   logic [DIGIT-1:0]   slice_sum;
   logic [DIGIT:0]     slice_c;
   logic [WIDTH-1:0]   res_next;
   logic               last_digit;

`ifdef SERIAL_ADDER_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   // One DIGIT-bit ripple slice fed from the low end of the operand shifters.
   always_comb begin
      slice_sum  = '0;
      slice_c    = '0;
      slice_c[0] = carry_q;
      for (int i = 0; i < DIGIT; i++) begin
         slice_sum[i]   = a_q[i] ^ b_q[i] ^ slice_c[i];
         slice_c[i + 1] = (a_q[i] & b_q[i]) | (slice_c[i] & (a_q[i] ^ b_q[i]));
      end
   end

   assign res_next   = (res_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
   assign last_digit = (cnt_q == CNT_W'(N - 1));

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      res_d       = res_q;
      sum_d       = sum_q;
      carry_out_d = carry_out_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d       = ovf_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               // Subtract is A + ~B + ~borrow, so the slice only ever adds.
               state_d = RUN;
               a_d     = a_in;
               b_d     = sub_in ? ~b_in : b_in;
               carry_d = sub_in ? ~c_in : c_in;
               cnt_d   = '0;
               res_d   = '0;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = slice_c[DIGIT];
            res_d   = res_next;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_digit) begin
               state_d     = DONE;
               sum_d       = res_next;
               carry_out_d = slice_c[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d       = slice_c[DIGIT - 1] ^ slice_c[DIGIT];
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         res_q       <= '0;
         sum_q       <= '0;
         carry_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         sum_q       <= sum_d;
         carry_out_q <= carry_out_d;
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign overflow_out = ovf_q;
`endif

   assign sum_out   = sum_q;
   assign carry_out = carry_out_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: two serial_adder instances (DIGIT=1 and DIGIT=4) against a cycle-level arithmetic model.
module tb_serial_adder;

   logic       clock;
   logic       reset;
   logic       start;
   logic       sub_in;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       c_in;

   logic [7:0] sum1, sum4;
   logic       carry1, carry4, busy1, busy4, done1, done4;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf1, ovf4;
`endif

   int checks;
   int failures;
   bit chkEn;
   int lat1, lat4, busyCnt;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
      .clock(clock), .reset(reset), .start(start), .sub_in(sub_in),
      .a_in(a_in), .b_in(b_in), .c_in(c_in),
      .sum_out(sum1), .carry_out(carry1), .busy(busy1), .done(done1)
`ifdef SERIAL_ADDER_OVF_EN
      , .overflow_out(ovf1)
`endif
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
      .clock(clock), .reset(reset), .start(start), .sub_in(sub_in),
      .a_in(a_in), .b_in(b_in), .c_in(c_in),
      .sum_out(sum4), .carry_out(carry4), .busy(busy4), .done(done4)
`ifdef SERIAL_ADDER_OVF_EN
      , .overflow_out(ovf4)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: index 0 tracks DIGIT=1 (8 compute cycles), index 1 tracks DIGIT=4 (2 cycles).
   int         rem[2];
   logic [7:0] pendSum[2];
   logic       pendCarry[2];
   logic       pendOvf[2];
   logic [7:0] expSum[2];
   logic       expCarry[2];
   logic       expOvf[2];
   logic       expDone[2];

   function automatic int computeCycles(input int m);
      return (m == 0) ? 8 : 2;
   endfunction

   function automatic logic [9:0] opModel(input logic [7:0] a, input logic [7:0] b,
                                          input logic sub, input logic c);
      int ua, ub, uc, r, sa, sb, sr;
      logic [7:0] s;
      logic co, ov;
      ua = int'(a); ub = int'(b); uc = int'(c);
      sa = (ua > 127) ? ua - 256 : ua;
      sb = (ub > 127) ? ub - 256 : ub;
      if (sub) begin
         r  = ua - ub - uc;
         co = (r >= 0);
         sr = sa - sb - uc;
      end else begin
         r  = ua + ub + uc;
         co = (r > 255);
         sr = sa + sb + uc;
      end
      s  = 8'(r);
      ov = (sr > 127) || (sr < -128);
      return {ov, co, s};
   endfunction

   always @(posedge clock) begin
      for (int m = 0; m < 2; m++) begin
         logic [9:0] res;
         res = opModel(a_in, b_in, sub_in, c_in);
         if (reset) begin
            rem[m]      <= 0;
            expSum[m]   <= 8'h00;
            expCarry[m] <= 1'b0;
            expOvf[m]   <= 1'b0;
            expDone[m]  <= 1'b0;
         end else if (rem[m] > 0) begin
            rem[m] <= rem[m] - 1;
            if (rem[m] == 1) begin
               expSum[m]   <= pendSum[m];
               expCarry[m] <= pendCarry[m];
               expOvf[m]   <= pendOvf[m];
               expDone[m]  <= 1'b1;
            end
         end else begin
            expDone[m] <= 1'b0;
            if (start) begin
               rem[m]       <= computeCycles(m);
               pendSum[m]   <= res[7:0];
               pendCarry[m] <= res[8];
               pendOvf[m]   <= res[9];
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle, both instances are compared with the model.
   always @(negedge clock) begin
      if (chkEn) begin
         checkOutput("dut1.busy", 32'(busy1), 32'(rem[0] > 0));
         checkOutput("dut1.done", 32'(done1), 32'(expDone[0]));
         checkOutput("dut1.sum", 32'(sum1), 32'(expSum[0]));
         checkOutput("dut1.carry", 32'(carry1), 32'(expCarry[0]));
         checkOutput("dut4.busy", 32'(busy4), 32'(rem[1] > 0));
         checkOutput("dut4.done", 32'(done4), 32'(expDone[1]));
         checkOutput("dut4.sum", 32'(sum4), 32'(expSum[1]));
         checkOutput("dut4.carry", 32'(carry4), 32'(expCarry[1]));
`ifdef SERIAL_ADDER_OVF_EN
         checkOutput("dut1.ovf", 32'(ovf1), 32'(expOvf[0]));
         checkOutput("dut4.ovf", 32'(ovf4), 32'(expOvf[1]));
`endif
      end
   end

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic sub, input logic c);
      @(negedge clock);
      a_in   = a;
      b_in   = b;
      sub_in = sub;
      c_in   = c;
      start  = 1'b1;
   endtask

   task automatic runOp(input logic [7:0] a, input logic [7:0] b,
                        input logic sub, input logic c);
      applyStimulus(a, b, sub, c);
      lat1 = 0; lat4 = 0; busyCnt = 0;
      for (int cyc = 1; cyc <= 20 && lat1 == 0; cyc++) begin
         @(negedge clock);
         if (cyc == 1) start = 1'b0;
         if (busy1) busyCnt++;
         if (done4 && lat4 == 0) lat4 = cyc;
         if (done1) lat1 = cyc;
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   initial begin
      int first4, second4, doneCount;
      checks = 0; failures = 0; chkEn = 1'b0;
      reset = 1'b1; start = 1'b0; sub_in = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
      idleCycles(3);
      chkEn = 1'b1;
      checkOutput("reset.sum1", 32'(sum1), 32'h0);
      checkOutput("reset.busy1", 32'(busy1), 32'h0);
      checkOutput("reset.done4", 32'(done4), 32'h0);
      reset = 1'b0;
      idleCycles(2);

      runOp(8'hFF, 8'h01, 1'b0, 1'b0);
      checkOutput("ffp01.latency1", 32'(lat1), 32'd9);
      checkOutput("ffp01.latency4", 32'(lat4), 32'd3);
      checkOutput("ffp01.busycycles", 32'(busyCnt), 32'd8);
      checkOutput("ffp01.sum", 32'(sum1), 32'h00);
      checkOutput("ffp01.carry", 32'(carry1), 32'h1);

      runOp(8'h05, 8'h07, 1'b1, 1'b0);
      checkOutput("05m07.sum", 32'(sum1), 32'hFE);
      checkOutput("05m07.carry", 32'(carry1), 32'h0);
      checkOutput("05m07.sum4", 32'(sum4), 32'hFE);

      runOp(8'h07, 8'h05, 1'b1, 1'b1);
      checkOutput("07m05.sum", 32'(sum1), 32'h01);
      checkOutput("07m05.carry", 32'(carry1), 32'h1);

      // Start held high: DIGIT=4 instance must produce a done every 3 cycles.
      applyStimulus(8'h3C, 8'h4B, 1'b0, 1'b1);
      first4 = 0; second4 = 0;
      for (int cyc = 1; cyc <= 12 && second4 == 0; cyc++) begin
         @(negedge clock);
         if (done4) begin
            if (first4 == 0) begin
               first4 = cyc;
               checkOutput("3cp4b.sum4", 32'(sum4), 32'h88);
               checkOutput("3cp4b.carry4", 32'(carry4), 32'h0);
            end else begin
               second4 = cyc;
            end
         end
      end
      start = 1'b0;
      checkOutput("held.first4", 32'(first4), 32'd3);
      checkOutput("held.gap4", 32'(second4 - first4), 32'd3);
      idleCycles(12);

      // A second start during RUN must be ignored by the DIGIT=1 instance.
      applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
      doneCount = 0;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(negedge clock);
         if (cyc == 1) start = 1'b0;
         if (cyc == 3) begin
            a_in = 8'hFF; b_in = 8'hFF; sub_in = 1'b1; c_in = 1'b1; start = 1'b1;
         end
         if (cyc == 4) start = 1'b0;
         if (done1) doneCount++;
      end
      checkOutput("ignore.donecount", 32'(doneCount), 32'd1);
      checkOutput("ignore.sum", 32'(sum1), 32'h46);

      // Reset in the middle of RUN aborts the operation.
      applyStimulus(8'h55, 8'h22, 1'b0, 1'b0);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clock);
         if (cyc == 1) start = 1'b0;
      end
      reset = 1'b1;
      @(negedge clock);
      checkOutput("abort.busy", 32'(busy1), 32'h0);
      checkOutput("abort.sum", 32'(sum1), 32'h0);
      checkOutput("abort.done", 32'(done1), 32'h0);
      reset = 1'b0;
      runOp(8'h20, 8'h0A, 1'b1, 1'b0);
      checkOutput("afterabort.sum", 32'(sum1), 32'h16);
      checkOutput("afterabort.carry", 32'(carry1), 32'h1);

`ifdef SERIAL_ADDER_OVF_EN
      runOp(8'h7F, 8'h01, 1'b0, 1'b0);
      checkOutput("ovf.7fp01.sum", 32'(sum1), 32'h80);
      checkOutput("ovf.7fp01", 32'(ovf1), 32'h1);
      runOp(8'h80, 8'h01, 1'b1, 1'b0);
      checkOutput("ovf.80m01.sum", 32'(sum1), 32'h7F);
      checkOutput("ovf.80m01", 32'(ovf1), 32'h1);
      runOp(8'h10, 8'h10, 1'b0, 1'b0);
      checkOutput("ovf.10p10", 32'(ovf1), 32'h0);
`endif

      // Random traffic: sporadic starts, random operands, rare resets.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         reset  = ($urandom_range(0, 299) == 0);
         start  = ($urandom_range(0, 3) == 0);
         a_in   = 8'($urandom);
         b_in   = 8'($urandom);
         sub_in = 1'($urandom_range(0, 1));
         c_in   = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      idleCycles(12);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
